// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for one shared ALU
//
// Accepts one operation at a time from two requesters, issues it to an
// external registered ALU, captures the result and returns it on a single
// response channel.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready[1:0]  per-requester handshake
//   req_op/req_lhs/req_rhs    per-requester operands, requester i in slice i
//   alu_op/alu_lhs/alu_rhs    operands to the shared ALU
//   alu_res/alu_flags         result from the shared ALU
//   resp_valid/resp_ready     response handshake
//   resp_id                   index of the requester being answered
//   resp_data/resp_flags      captured result, zero on error
//   resp_err                  opcode was outside the supported range
//   busy                      a transaction is in flight
//   done_cnt                  completed responses, wraps at 16 bits

module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          req_valid,
   output logic [1:0]          req_ready,
   input  logic [2*OP_W-1:0]   req_op,
   input  logic [2*DATA_W-1:0] req_lhs,
   input  logic [2*DATA_W-1:0] req_rhs,
   output logic [OP_W-1:0]     alu_op,
   output logic [DATA_W-1:0]   alu_lhs,
   output logic [DATA_W-1:0]   alu_rhs,
   input  logic [DATA_W-1:0]   alu_res,
   input  logic [3:0]          alu_flags,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic                resp_id,
   output logic [DATA_W-1:0]   resp_data,
   output logic [3:0]          resp_flags,
   output logic                resp_err,
   output logic                busy,
   output logic [15:0]         done_cnt
);

   localparam logic [OP_W-1:0] OP_MAX = OP_W'(11);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_CAPTURE,
      ST_RESP
   } state_t;

   state_t              state_q, state_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [DATA_W-1:0]   lhs_q, lhs_d;
   logic [DATA_W-1:0]   rhs_q, rhs_d;
   logic                idx_q, idx_d;
   logic                last_grant_q, last_grant_d;
   logic [DATA_W-1:0]   resp_data_q, resp_data_d;
   logic [3:0]          resp_flags_q, resp_flags_d;
   logic                resp_err_q, resp_err_d;
   logic                resp_valid_q, resp_valid_d;
   logic                busy_q, busy_d;
   logic [15:0]         done_cnt_q, done_cnt_d;

   logic                gnt_valid;
   logic                gnt_idx;
   logic [OP_W-1:0]     sel_op;
   logic [DATA_W-1:0]   sel_lhs;
   logic [DATA_W-1:0]   sel_rhs;
   logic                accept;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = 1'b0;
      case (req_valid)
         2'b01:   begin gnt_valid = 1'b1; gnt_idx = 1'b0;          end
         2'b10:   begin gnt_valid = 1'b1; gnt_idx = 1'b1;          end
         2'b11:   begin gnt_valid = 1'b1; gnt_idx = ~last_grant_q; end
         default: begin gnt_valid = 1'b0; gnt_idx = 1'b0;          end
      endcase
   end

   assign req_ready = (state_q == ST_IDLE && gnt_valid) ? {gnt_idx, ~gnt_idx} : 2'b00;
   assign accept    = (state_q == ST_IDLE) && gnt_valid;

   assign sel_op  = gnt_idx ? req_op[2*OP_W-1:OP_W]       : req_op[OP_W-1:0];
   assign sel_lhs = gnt_idx ? req_lhs[2*DATA_W-1:DATA_W]  : req_lhs[DATA_W-1:0];
   assign sel_rhs = gnt_idx ? req_rhs[2*DATA_W-1:DATA_W]  : req_rhs[DATA_W-1:0];

   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      lhs_d        = lhs_q;
      rhs_d        = rhs_q;
      idx_d        = idx_q;
      last_grant_d = last_grant_q;
      resp_data_d  = resp_data_q;
      resp_flags_d = resp_flags_q;
      resp_err_d   = resp_err_q;
      done_cnt_d   = done_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               idx_d        = gnt_idx;
               last_grant_d = gnt_idx;
               if (sel_op <= OP_MAX) begin
                  // ALU operand registers only move for ops the ALU will
                  // execute, so an error request leaves the ALU ports quiet.
                  op_d    = sel_op;
                  lhs_d   = sel_lhs;
                  rhs_d   = sel_rhs;
                  state_d = ST_ISSUE;
               end else begin
                  resp_data_d  = '0;
                  resp_flags_d = 4'h0;
                  resp_err_d   = 1'b1;
                  state_d      = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            resp_data_d  = alu_res;
            resp_flags_d = alu_flags;
            resp_err_d   = 1'b0;
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (resp_ready) begin
               done_cnt_d = done_cnt_q + 16'd1;
               state_d    = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      resp_valid_d = (state_d == ST_RESP);
      busy_d       = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         op_q         <= '0;
         lhs_q        <= '0;
         rhs_q        <= '0;
         idx_q        <= 1'b0;
         last_grant_q <= 1'b1;
         resp_data_q  <= '0;
         resp_flags_q <= 4'h0;
         resp_err_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_cnt_q   <= 16'h0000;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         lhs_q        <= lhs_d;
         rhs_q        <= rhs_d;
         idx_q        <= idx_d;
         last_grant_q <= last_grant_d;
         resp_data_q  <= resp_data_d;
         resp_flags_q <= resp_flags_d;
         resp_err_q   <= resp_err_d;
         resp_valid_q <= resp_valid_d;
         busy_q       <= busy_d;
         done_cnt_q   <= done_cnt_d;
      end
   end

   assign alu_op     = op_q;
   assign alu_lhs    = lhs_q;
   assign alu_rhs    = rhs_q;
   assign resp_valid = resp_valid_q;
   assign resp_id    = idx_q;
   assign resp_data  = resp_data_q;
   assign resp_flags = resp_flags_q;
   assign resp_err   = resp_err_q;
   assign busy       = busy_q;
   assign done_cnt   = done_cnt_q;

endmodule
